// File: rtl/nd_2to1_arb_pkg.sv
// Shared sizes, switches, FSM state codes and helpers for the 2-to-1 arbiter.
package nd_2to1_arb_pkg;

    localparam int NS_ADDRESS_SIZE = 4;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REDUN_SIZE   = 4;

    localparam bit NS_ON  = 1'b1;
    localparam bit NS_OFF = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SEND  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    // Drop counter stops at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/nd_2to1_arb_if.sv
// Four-phase message channel: req/ack plus src/dst/dat/red fields.
interface nd_2to1_arb_if
    import nd_2to1_arb_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE
);
    logic           req;
    logic           ack;
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;

    modport master (output req, src, dst, dat, red, input ack);
    modport slave  (input req, src, dst, dat, red, output ack);
endinterface

// File: rtl/nd_2to1_arb_calc_redun.sv
// Redundancy code: XOR-fold of {src, dst, dat} into RSZ-bit chunks
// (zero-padded at the top when the message width is not a multiple of RSZ).
module calc_redun
    import nd_2to1_arb_pkg::*;
#(
    parameter int ASZ = NS_ADDRESS_SIZE,
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE
) (
    input  logic [ASZ-1:0] i_src,
    input  logic [ASZ-1:0] i_dst,
    input  logic [DSZ-1:0] i_dat,
    output logic [RSZ-1:0] o_red
);
    localparam int TOT = 2 * ASZ + DSZ;
    localparam int NCH = (TOT + RSZ - 1) / RSZ;

    logic [NCH*RSZ-1:0] w_vec;

    // Pad the message and fold it chunk by chunk.
    always_comb begin
        w_vec          = '0;
        w_vec[TOT-1:0] = {i_src, i_dst, i_dat};
        o_red          = '0;
        for (int j = 0; j < NCH; j++) begin
            o_red = o_red ^ w_vec[j*RSZ +: RSZ];
        end
    end
endmodule

// File: rtl/nd_2to1_arb.sv
// Round-robin merge of two four-phase inbound channels onto one outbound channel
// through a single-message buffer, with optional redundancy check and drop count.
//
//  state    | meaning
//  ST_IDLE  | buffer empty, waiting for an eligible input
//  ST_CHECK | buffer just latched, redundancy being evaluated
//  ST_SEND  | o0_req high, waiting for o0_ack
//  ST_DRAIN | o0_req low, waiting for o0_ack to fall
module nd_2to1_arb
    import nd_2to1_arb_pkg::*;
#(
    parameter int ASZ        = NS_ADDRESS_SIZE,
    parameter int DSZ        = NS_DATA_SIZE,
    parameter int RSZ        = NS_REDUN_SIZE,
    parameter bit CHK_REDUN  = NS_ON,
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic                i_clk,
    input  logic                reset,
    nd_2to1_arb_if.slave        i0,
    nd_2to1_arb_if.slave        i1,
    nd_2to1_arb_if.master       o0,
    output logic                err,
    output logic [7:0]          err_cnt,
    output logic                last_grant
);
    arb_state_e     r_state;
    arb_state_e     w_state_nxt;
    logic           r_ptr;
    logic           r_last;
    logic           r_ack0;
    logic           r_ack1;
    logic           r_oreq;
    logic           r_err;
    logic [7:0]     r_err_cnt;
    logic [ASZ-1:0] r_src;
    logic [ASZ-1:0] r_dst;
    logic [DSZ-1:0] r_dat;
    logic [RSZ-1:0] r_red;

    logic           w_elig0;
    logic           w_elig1;
    logic           w_grant;
    logic           w_sel;
    logic           w_fwd;
    logic           w_drop;
    logic           w_oreq_clr;
    logic           w_retire;
    logic           w_red_ok;
    logic [RSZ-1:0] w_calc;

    // An input that is still holding ack high cannot be picked again.
    assign w_elig0 = i0.req & ~r_ack0;
    assign w_elig1 = i1.req & ~r_ack1;

    calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_calc_redun (
        .i_src (r_src),
        .i_dst (r_dst),
        .i_dat (r_dat),
        .o_red (w_calc)
    );

    assign w_red_ok = (CHK_REDUN == 1'b0) || (w_calc == r_red);

    // Next state and the single-cycle actions taken on the coming edge.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel       = r_ptr;
        w_fwd       = 1'b0;
        w_drop      = 1'b0;
        w_oreq_clr  = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_elig0 | w_elig1) begin
                    w_grant     = 1'b1;
                    w_sel       = (w_elig0 & w_elig1) ? r_ptr : w_elig1;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_red_ok) begin
                    w_fwd       = 1'b1;
                    w_state_nxt = ST_SEND;
                end else begin
                    w_drop      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (o0.ack) begin
                    w_oreq_clr  = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!o0.ack) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, fairness pointer, outbound request and error tracking.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= FIRST_PRIO;
            r_last    <= FIRST_PRIO;
            r_oreq    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) r_last <= w_sel;
            if (w_fwd) r_oreq <= 1'b1;
            if (w_oreq_clr) r_oreq <= 1'b0;
            if (w_drop) begin
                r_err     <= 1'b1;
                r_err_cnt <= sat_inc8(r_err_cnt);
            end
            // Hand priority to the other input whether the message went out or was dropped.
            if (w_drop | w_retire) r_ptr <= ~r_last;
        end
    end

    // Inbound acks run independently of the outbound side so a source can retire early.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
        end else begin
            if (w_grant && !w_sel) r_ack0 <= 1'b1;
            else if (!i0.req)      r_ack0 <= 1'b0;
            if (w_grant && w_sel)  r_ack1 <= 1'b1;
            else if (!i1.req)      r_ack1 <= 1'b0;
        end
    end

    // Message buffer, loaded only on the grant edge.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            r_src <= '0;
            r_dst <= '0;
            r_dat <= '0;
            r_red <= '0;
        end else if (w_grant) begin
            r_src <= w_sel ? i1.src : i0.src;
            r_dst <= w_sel ? i1.dst : i0.dst;
            r_dat <= w_sel ? i1.dat : i0.dat;
            r_red <= w_sel ? i1.red : i0.red;
        end
    end

    assign i0.ack     = r_ack0;
    assign i1.ack     = r_ack1;
    assign o0.req     = r_oreq;
    assign o0.src     = r_src;
    assign o0.dst     = r_dst;
    assign o0.dat     = r_dat;
    assign o0.red     = r_red;
    assign err        = r_err;
    assign err_cnt    = r_err_cnt;
    assign last_grant = r_last;
endmodule
